// File: rtl/circle_dispatch.sv
// circle_dispatch: command scheduler for a bank of circle-plotting engines.
// Host commands are buffered in a FIFO. Circles are issued round-robin to
// idle engines, and a clear command drains the bank and then sweeps every
// pixel address with broadcast writes.
// Optional build macro CIRCLE_DISPATCH_STATS_EN adds the stat_circles and
// stat_stall counter outputs.
//
// state    | meaning
// S_IDLE   | inspect FIFO head, choose an engine or start a drain
// S_DISPATCH | issue the circle write, pop the FIFO, arm the engine timer
// S_DRAIN  | clear at head, waiting for every engine timer to reach 0
// S_CLEAR  | broadcast sweep, one write per pixel address
module circle_dispatch #(
  parameter int ENGINES    = 11,
  parameter int DATAW      = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [26:0]      cmd_data,
  output logic             write,
  output logic [DATAW-1:0] address,
  output logic [31:0]      writedata,
  output logic             idle,
  output logic             clear_done
`ifdef CIRCLE_DISPATCH_STATS_EN
  ,
  output logic [15:0]      stat_circles,
  output logic [15:0]      stat_stall
`endif
);

  localparam int EW = (ENGINES > 1) ? $clog2(ENGINES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [EW-1:0] LAST_RST = EW'(ENGINES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_CLEAR    = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [26:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          push, pop, empty;
  logic [26:0]   head;
  logic          head_clear;
  logic [7:0]    head_radius;
  logic [17:0]   head_yx;

  logic [10:0]        timer    [ENGINES];
  logic [10:0]        timer_nx [ENGINES];
  logic [10:0]        load_val;
  logic [ENGINES-1:0] free;
  logic               all_zero, all_zero_nx;
  logic [EW-1:0]      last, pick, sel_q;
  logic               found;
  logic               do_dispatch, do_clear_start, sweep_end, stall;

  assign empty       = (count == '0);
  assign push        = cmd_valid & cmd_ready;
  assign head        = fifo_mem[rd_ptr];
  assign head_clear  = head[26];
  assign head_radius = head[25:18];
  assign head_yx     = head[17:0];
  // Conservative busy bound: 4*r+8 cycles.
  assign load_val    = {1'b0, head_radius, 2'b00} + 11'd8;

  // Wrapped engine index for the round-robin search.
  function automatic logic [EW-1:0] rr_idx(input logic [EW-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= ENGINES) j = j - ENGINES;
    return EW'(j);
  endfunction

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // FIFO storage; contents need no reset since count guards the head.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_data;
  end

  // FIFO pointers, count and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nx;
      cmd_ready <= (count_nx != FULL_CNT);
    end
  end

  // Free flags and first free engine after the last one dispatched.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    all_zero = 1'b1;
    free     = '0;
    for (int i = 0; i < ENGINES; i++) begin
      free[i] = (timer[i] == '0);
      if (timer[i] != '0) all_zero = 1'b0;
    end
    for (int i = 0; i < ENGINES; i++) begin
      if (!found && free[rr_idx(last, i + 1)]) begin
        found = 1'b1;
        pick  = rr_idx(last, i + 1);
      end
    end
  end

  // Saturating down-count, overridden by a load on dispatch.
  always_comb begin
    all_zero_nx = 1'b1;
    for (int i = 0; i < ENGINES; i++) begin
      timer_nx[i] = (timer[i] != '0) ? timer[i] - 1'b1 : '0;
      if (do_dispatch && (sel_q == EW'(i))) timer_nx[i] = load_val;
      if (timer_nx[i] != '0) all_zero_nx = 1'b0;
    end
  end

  // Engine busy timers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENGINES; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < ENGINES; i++) timer[i] <= timer_nx[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx       = state;
    pop            = 1'b0;
    do_dispatch    = 1'b0;
    do_clear_start = 1'b0;
    sweep_end      = 1'b0;
    stall          = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head_clear)  state_nx = S_DRAIN;
          else if (found)  state_nx = S_DISPATCH;
          else             stall    = 1'b1;
        end
      end
      S_DISPATCH: begin
        pop         = 1'b1;
        do_dispatch = 1'b1;
        state_nx    = S_IDLE;
      end
      S_DRAIN: begin
        if (all_zero) begin
          pop            = 1'b1;
          do_clear_start = 1'b1;
          state_nx       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (address == '1) begin
          sweep_end = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Round-robin pointer and the engine latched for the pending dispatch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last  <= LAST_RST;
      sel_q <= '0;
    end else begin
      if (state == S_IDLE) sel_q <= pick;
      if (do_dispatch)     last  <= sel_q;
    end
  end

  // Registered write port, sweep address, status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      clear_done <= 1'b0;
      idle       <= 1'b1;
    end else begin
      write      <= 1'b0;
      clear_done <= 1'b0;
      idle       <= (state_nx == S_IDLE) && (count_nx == '0) && all_zero_nx;
      if (do_dispatch) begin
        write     <= 1'b1;
        writedata <= {6'(sel_q) + 6'd1, head_radius, head_yx};
      end
      if (do_clear_start) begin
        write     <= 1'b1;
        address   <= '0;
        writedata <= '0;
      end else if (state == S_CLEAR) begin
        if (sweep_end) begin
          clear_done <= 1'b1;
          address    <= '0;
        end else begin
          write   <= 1'b1;
          address <= address + 1'b1;
        end
      end
    end
  end

`ifdef CIRCLE_DISPATCH_STATS_EN
  // Dispatch count wraps; stall count saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_circles <= '0;
      stat_stall   <= '0;
    end else begin
      if (do_dispatch)                  stat_circles <= stat_circles + 1'b1;
      if (stall && (stat_stall != '1))  stat_stall   <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_circle_dispatch.sv
// Scoreboard bench for circle_dispatch, built with a 10-bit pixel address so
// a full clear sweep is 1024 writes.
module tb_circle_dispatch;

  localparam int TB_DATAW = 10;
  localparam logic [TB_DATAW-1:0] ADDR_MAX = '1;
  localparam int NSWEEP = 1 << TB_DATAW;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [26:0]         cmd_data = '0;
  logic                write;
  logic [TB_DATAW-1:0] address;
  logic [31:0]         writedata;
  logic                idle;
  logic                clear_done;
`ifdef CIRCLE_DISPATCH_STATS_EN
  logic [15:0]         stat_circles;
  logic [15:0]         stat_stall;
`endif

  circle_dispatch #(.ENGINES(11), .DATAW(TB_DATAW), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .idle       (idle),
    .clear_done (clear_done)
`ifdef CIRCLE_DISPATCH_STATS_EN
    ,
    .stat_circles (stat_circles),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]         wd;
    logic [TB_DATAW-1:0] addr;
    bit                  is_clr;
  } exp_t;

  exp_t sb[$];
  int   wr_log[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  bit   last_was_final = 0;

  always @(posedge clk) cyc++;

  // Monitor: every write pops the scoreboard; clear_done must follow the final sweep write.
  always @(negedge clk) begin
    exp_t e;
    if (reset && clear_done) begin
      tests++;
      done_cnt++;
      if (!last_was_final) begin
        fails++;
        $display("FAIL clear_done_position: pulse at cycle %0d, required right after final sweep write", cyc);
      end
    end
    last_was_final = 0;
    if (reset && write) begin
      wr_log.push_back(cyc);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: writedata=%h address=%0d, required no write", writedata, address);
      end else begin
        e = sb.pop_front();
        if (writedata !== e.wd || (e.is_clr && address !== e.addr)) begin
          fails++;
          $display("FAIL write_check: writedata=%h address=%0d, required writedata=%h address=%0d",
                   writedata, address, e.wd, e.addr);
        end
        if (e.is_clr && e.addr == ADDR_MAX) last_was_final = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [26:0] mk_cmd(input bit clr, input int r, input int y, input int x);
    return {clr, 8'(r), 9'(y), 9'(x)};
  endfunction

  task automatic exp_circle(input int id, input int r, input int y, input int x);
    exp_t e;
    e.wd = {6'(id), 8'(r), 9'(y), 9'(x)};
    e.addr = '0;
    e.is_clr = 0;
    sb.push_back(e);
  endtask

  task automatic exp_sweep();
    exp_t e;
    for (int i = 0; i < NSWEEP; i++) begin
      e.wd = '0;
      e.addr = TB_DATAW'(i);
      e.is_clr = 1;
      sb.push_back(e);
    end
  endtask

  int acc_cyc;

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [26:0] d);
    int t = 0;
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready_timeout", (t < 3000), 1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int t = 0;
    while ((sb.size() != 0 || !idle) && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_timeout"}, (t < limit), 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    sb.delete();
    wr_log.delete();
    done_cnt = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_idle", idle, 1);
  endtask

  initial begin
    int t;
    int accepts;

    // T1: single circle, latency and idle return after the 4r+8 bound.
    do_reset();
    exp_circle(1, 20, 50, 100);
    push(mk_cmd(0, 20, 50, 100));
    t = 0;
    while (wr_log.size() < 1 && t < 20) begin @(negedge clk); t++; end
    chk("t1_write_seen", (wr_log.size() >= 1), 1);
    if (wr_log.size() >= 1) begin
      chk("t1_write_latency", wr_log[0] - acc_cyc, 2);
      t = 0;
      while (!idle && t < 300) begin @(negedge clk); t++; end
      chk("t1_idle_latency", cyc - wr_log[0], 88);
    end
    wait_done("t1", 300);

    // T2: twelve circles over eleven engines; the twelfth waits for engine 1.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      exp_circle((i % 11) + 1, 10, 2 * i, i);
      push(mk_cmd(0, 10, 2 * i, i));
    end
    wait_done("t2", 400);
    chk("t2_write_count", wr_log.size(), 12);
    if (wr_log.size() >= 12) begin
      chk("t2_gap_first_to_eleventh", wr_log[10] - wr_log[0], 20);
      chk("t2_gap_first_to_twelfth", wr_log[11] - wr_log[0], 50);
    end

    // T3: all engines busy, FIFO fills to 16 and the 17th waits for a pop.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      exp_circle(i + 1, 255, 1, i);
      push(mk_cmd(0, 255, 1, i));
    end
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    chk("t3_busy_fill", sb.size(), 0);
    accepts = 0;
    cmd_data  = mk_cmd(0, 1, 3, 7);
    cmd_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (cmd_ready) begin
        exp_circle((accepts % 11) + 1, 1, 3, 7);
        accepts++;
      end
      @(negedge clk);
    end
    chk("t3_accepts_when_full", accepts, 16);
    chk("t3_ready_low_when_full", cmd_ready, 0);
    t = 0;
    while (accepts < 17 && t < 1500) begin
      if (cmd_ready) begin
        exp_circle((accepts % 11) + 1, 1, 3, 7);
        accepts++;
      end
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    chk("t3_seventeenth_accepted", accepts, 17);
    chk("t3_seventeenth_after_pop", (t > 900), 1);
    wait_done("t3", 3000);

    // T4: circle, clear, circle; drain, full sweep, clear_done, then circle.
    do_reset();
    exp_circle(1, 10, 1, 1);
    push(mk_cmd(0, 10, 1, 1));
    exp_sweep();
    push(mk_cmd(1, 0, 0, 0));
    exp_circle(2, 5, 3, 2);
    push(mk_cmd(0, 5, 3, 2));
    wait_done("t4", 3000);
    chk("t4_clear_done_pulses", done_cnt, 1);
    chk("t4_write_count", wr_log.size(), NSWEEP + 2);
    if (wr_log.size() >= NSWEEP + 2) begin
      chk("t4_drain_gap", wr_log[1] - wr_log[0], 49);
      chk("t4_sweep_length", wr_log[NSWEEP] - wr_log[1], NSWEEP - 1);
      chk("t4_post_sweep_gap", wr_log[NSWEEP + 1] - wr_log[NSWEEP], 3);
    end

    // T5: reset in the middle of a sweep abandons it.
    do_reset();
    exp_sweep();
    push(mk_cmd(1, 0, 0, 0));
    t = 0;
    while (!(write && address == TB_DATAW'(1000)) && t < 2000) begin @(negedge clk); t++; end
    chk("t5_reached_addr_1000", (t < 2000), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_write", write, 0);
    chk("t5_rst_address", address, 0);
    chk("t5_rst_cmd_ready", cmd_ready, 0);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_idle_after_release", idle, 1);
    chk("t5_ready_after_release", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("t5_still_idle", idle, 1);
    chk("t5_no_write", write, 0);

`ifdef CIRCLE_DISPATCH_STATS_EN
    // T6: statistics counters after five unstalled dispatches.
    do_reset();
    chk("t6_stat_circles_rst", stat_circles, 0);
    for (int i = 0; i < 5; i++) begin
      exp_circle(i + 1, 0, i, i);
      push(mk_cmd(0, 0, i, i));
    end
    wait_done("t6", 200);
    chk("t6_stat_circles", stat_circles, 5);
    chk("t6_stat_stall", stat_stall, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circle_dispatch.md
# circle_dispatch

Command scheduler for the bank of parallel circle-plotting engines. Accepts circle and frame-clear commands from a host stream, queues them in a FIFO, and issues them over the engine bank's shared memory-mapped write port. Circles go round-robin to idle engines; each engine's busy state is tracked with a conservative per-engine timer. A clear command drains all engines, then sweeps every pixel address with a broadcast (ID 0) write.

## Interface
- ENGINES, 11, number of engines; engine IDs are 1..ENGINES (max 63)
- DATAW, 18, pixel address width; x = low DATAW/2 bits, y = high DATAW/2 bits
- FIFO_DEPTH, 16, command FIFO entries (power of two)

- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_data  in  27  [26]=clear op, [25:18]=radius, [17:9]=y, [8:0]=x
- write  out  1  write strobe to engine bank
- address  out  DATAW  pixel address; used only by clear writes
- writedata  out  32  [31:26]=engine ID (0=broadcast), [25:18]=radius, [17:0]={y,x}
- idle  out  1  FIFO empty, all timers zero, FSM in IDLE
- clear_done  out  1  one-cycle pulse after the last clear write

## Operation
- FIFO push when cmd_valid & cmd_ready. cmd_ready = !full, where full comes from a registered count. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Busy timer per engine, 11 bits, saturating down-counter. Loaded with 4*radius+8 when that engine is dispatched. The engine is free when its timer is 0. This bound covers at most r/√2+2 iterations of 4 write cycles each.
- Round-robin pointer `last`, reset value ENGINES-1, meaning engine index 0 is searched first. The search runs from last+1, wraps, and picks the first free engine. `last` updates only on dispatch.
- FSM states:
  - IDLE
    - FIFO empty: stay.
    - Head is a circle and some engine is free: DISPATCH.
    - Head is a circle and no engine is free: stay.
    - Head is a clear: DRAIN.
  - DISPATCH (1 cycle)
    - write=1; writedata={ID, radius, y, x} with ID = chosen index + 1.
    - Pop the FIFO and load that engine's timer.
    - Return to IDLE.
  - DRAIN
    - Wait until all timers are 0, then pop the clear command, set address=0 and go to CLEAR.
  - CLEAR
    - write=1, writedata[31:26]=0, other writedata bits 0.
    - address increments every cycle.
    - At address 2^DATAW-1: pulse clear_done next cycle and go to IDLE.
- Strict command order is kept: circles queued behind a clear wait for the sweep to finish. Circles queued ahead of a clear finish before the sweep starts.
- Never more than one write per cycle. A busy engine is never re-targeted.
- Reset mid-operation: FIFO emptied, all timers 0, FSM to IDLE, any sweep in progress abandoned.

## Timing
- Reset values: write=0, address=0, writedata=0, clear_done=0, idle=1, cmd_ready=0 while reset is asserted and 1 from the first cycle after.
- All outputs are registered.
- A command accepted at edge N can reach the FIFO head no earlier than N+1. Its write is asserted no earlier than N+2, given an engine is free.
- Maximum circle throughput is one dispatch every 2 cycles (IDLE→DISPATCH).
- A clear takes 2^DATAW write cycles plus drain time.
- Timers decrement every cycle, including the cycle in which another engine is dispatched. A timer reaching 0 at edge N makes its engine eligible for the search in cycle N.

## Configuration
- CIRCLE_DISPATCH_STATS_EN defined: adds two outputs.
  - stat_circles, 16 bits: wrapping count of circle dispatches.
  - stat_stall, 16 bits: saturating count of IDLE cycles with a circle at the head and no engine free.
  - Both are 0 after reset.
- Undefined: neither port nor either counter exists. All other behaviour is identical.

## Test plan
- Reset, then push one circle x=100, y=50, r=20 → single write, writedata[31:26]=1, [25:18]=20, [17:0]={50,100}; idle returns after 88 cycles.
- Push 12 circles with ENGINES=11 → IDs 1..11 used in order; the 12th stalls until engine 1's timer expires, then goes to ID 1.
- Hold cmd_valid high with no engine free → cmd_ready drops after 16 accepts; the 17th command is held off until a pop.
- Push circle r=10, then clear, then circle r=5 → circle write, drain, 2^18 broadcast writes with address 0..262143, clear_done pulse, then the second circle dispatched.
- Assert reset in the middle of a sweep at address 1000 → write=0 and address=0 next cycle; idle=1 after reset releases.
- With CIRCLE_DISPATCH_STATS_EN defined, dispatch 5 circles → stat_circles=5.
